aes_round_ctrl: RTL and testbench

- Iterative sequencer for the AES encryption round datapath: byte substitution, row shift, column mix and round-key add.
- Holds the 128-bit state register and the round counter.
- Addresses the key schedule and tells the external combinational round datapath when the final round omits column mixing.
- Sits between the block input interface (valid/ready) and the ciphertext output interface (valid/ready); processes one block at a time.

---
 rtl/aes_round_ctrl.sv | 97 +++++++++
 tb/tb_aes_round_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer.
// Holds the 128-bit cipher state and the round counter. Drives the external
// combinational round datapath and key schedule one round per cycle. A block
// enters through a valid/ready input port and leaves through a valid/ready
// output port, with one block in flight at a time.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that transfer. The consumer may raise or lower ready freely.
// Ready never depends combinationally on valid.
//
// NR selects the key size: 10, 12 or 14 rounds (AES-128/192/256). Other
// values are not meaningful to the key schedule this controller addresses.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic [127:0] dp_state,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [1:0]   dbg_fsm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t         fsm_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;

    // Sequencer: initial key add on accept, one datapath round per cycle, then
    // hold the ciphertext until the output handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= 128'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // rk_idx is 0 here, so rk_data is the whitening key.
                        state_q <= in_block ^ rk_data;
                        round_q <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= dp_result;
                    if (round_q == LAST_ROUND) begin
                        round_q <= 4'd0;
                        fsm_q   <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    // The state is kept so out_block stays valid after the
                    // handshake as well. New input waits for IDLE.
                    if (out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    round_q <= 4'd0;
                end
            endcase
        end
    end

    // Interface outputs decoded straight from the registered state.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign dp_state  = state_q;
    assign out_block = state_q;
    assign rk_idx    = (fsm_q == ROUND) ? round_q : 4'd0;
    assign dp_final  = (fsm_q == ROUND) && (round_q == LAST_ROUND);
    assign dbg_fsm   = fsm_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl (NR=10). The bench
// provides a golden AES-128 key schedule and a combinational round datapath.
// It checks FIPS-197 C.1 and the handshake, latency, backpressure and reset
// behaviour.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    typedef logic [255:0][7:0]  sbox_t;
    typedef logic [15:0][127:0] rk_tab_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] dp_state;
    logic         dp_final;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [1:0]   dbg_fsm;

    sbox_t   sbox;
    rk_tab_t rk_tab;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int last_acc = 0;
    int mon_k;
    bit in_flight = 1'b0;
    logic [127:0] exp_q[$];

    aes_round_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .dp_state  (dp_state),
        .dp_final  (dp_final),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .dbg_fsm   (dbg_fsm)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- AES golden model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic sbox_t build_sbox();
        sbox_t      sb;
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        return sb;
    endfunction

    function automatic rk_tab_t key_expand(input logic [127:0] key, input sbox_t sb);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_tab_t     rk;
        rk = '0;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic fin, input sbox_t sb);
        logic [127:0] a, b;
        logic [7:0]   c0, c1, c2, c3;
        for (int k = 0; k < 16; k++) a[8*k+7 -: 8] = sb[s[8*k+7 -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[127-8*(4*c+r) -: 8] = a[127-8*(4*((c+r)%4)+r) -: 8];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                {c0, c1, c2, c3} = b[127-32*c -: 32];
                b[127-32*c -: 32] = {xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3,
                                     c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3,
                                     c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3,
                                     xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3)};
            end
        end
        return b ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input rk_tab_t rk,
                                                 input sbox_t sb);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], (r == NR), sb);
        return s;
    endfunction

    // Golden key schedule and round datapath seen by the DUT.
    assign rk_data   = rk_tab[rk_idx];
    assign dp_result = aes_round(dp_state, rk_data, dp_final, sbox);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_flight = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(aes_encrypt(in_block, rk_tab, sbox));
                check("acc_rk_idx", 128'(rk_idx), 128'd0);
                check("acc_dp_final", 128'(dp_final), 128'd0);
                last_acc  = cyc;
                in_flight = 1'b1;
            end else if (in_flight) begin
                mon_k = cyc - last_acc;
                if (mon_k >= 1 && mon_k <= NR) begin
                    check("rk_idx", 128'(rk_idx), 128'(mon_k));
                    check("dp_final", 128'(dp_final), 128'(mon_k == NR));
                    check("round_out_valid", 128'(out_valid), 128'd0);
                    check("round_in_ready", 128'(in_ready), 128'd0);
                end else if (mon_k == NR + 1) begin
                    check("latency_out_valid", 128'(out_valid), 128'd1);
                end
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                in_flight = 1'b0;
                if (exp_q.size() == 0) check("unexpected_output", 128'd1, 128'd0);
                else check("ciphertext", out_block, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] blk);
        int n;
        in_valid = 1'b1;
        in_block = blk;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        if (!in_ready) check("in_ready_timeout", 128'd0, 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        if (!out_valid) check("out_valid_timeout", 128'd0, 128'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, hs0;
        logic [127:0] held;
        sbox   = build_sbox();
        rk_tab = key_expand(KEY, sbox);
        rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_dp_final", 128'(dp_final), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_dp_state", dp_state, 128'd0);
        check("rst_out_block", out_block, 128'd0);
        check("rst_fsm", 128'(dbg_fsm), 128'd0);

        // FIPS-197 C.1 with out_ready high
        out_ready = 1'b1;
        send(PT);
        wait_out(n);
        check("c1_latency", 128'(n + 1), 128'(NR + 1));
        check("c1_ct", out_block, CT);
        check("c1_busy_done", 128'(busy), 128'd1);
        tick();
        check("c1_in_ready_after", 128'(in_ready), 128'd1);
        check("c1_out_valid_after", 128'(out_valid), 128'd0);

        // Backpressure: hold DONE for 20 cycles
        out_ready = 1'b0;
        send(PT);
        wait_out(n);
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_block", out_block, CT);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Busy rejection: in_valid held with changing data during ROUND
        in_valid = 1'b1;
        in_block = PT2;
        tick();
        for (int i = 0; i < 9; i++) begin
            in_block = PT2 ^ {4{32'(i * 32'h1357_9bdf + 32'h0f0f_0f0f)}};
            tick();
        end
        in_valid = 1'b0;
        wait_out(n);
        check("busy_ct", out_block, aes_encrypt(PT2, rk_tab, sbox));
        tick();

        // Back-to-back: two blocks offered continuously
        in_valid = 1'b1;
        in_block = PT;
        tick();
        in_block = ~PT;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        check("b2b_gap", 128'(n + 1), 128'(NR + 2));
        tick();
        in_valid = 1'b0;
        wait_out(n);
        check("b2b_ct2", out_block, aes_encrypt(~PT, rk_tab, sbox));
        tick();

        // Reset in round 5
        send(PT);
        repeat (4) tick();
        check("mid_rk_idx", 128'(rk_idx), 128'd5);
        hs0 = hs_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_fsm", 128'(dbg_fsm), 128'd0);
        check("mid_out_valid", 128'(out_valid), 128'd0);
        check("mid_busy", 128'(busy), 128'd0);
        check("mid_in_ready", 128'(in_ready), 128'd1);
        check("mid_out_block", out_block, 128'd0);
        repeat (14) tick();
        check("mid_no_output", 128'(hs_cnt), 128'(hs0));
        send(PT2);
        wait_out(n);
        check("mid_next_ct", out_block, aes_encrypt(PT2, rk_tab, sbox));
        tick();

        // Reset in DONE with out_ready high
        out_ready = 1'b0;
        send(PT);
        wait_out(n);
        held = out_block;
        check("done_ct", held, CT);
        hs0 = hs_cnt;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("done_rst_out_valid", 128'(out_valid), 128'd0);
        check("done_rst_in_ready", 128'(in_ready), 128'd1);
        check("done_rst_no_hs", 128'(hs_cnt), 128'(hs0));
        tick();

        check("hs_total", 128'(hs_cnt), 128'd6);
        check("exp_q_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
